// File: rtl/data_mem_responder_if.sv
// Load/store request and response handshake bundle between the core (master)
// and the data-memory responder (slave).
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: one request at a time, WAIT_STATES wait cycles, word RAM with byte lanes.
// Optional memory-mapped output register enabled by defining MMIO_OUT_EN.
module data_mem_responder #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 1
`ifdef MMIO_OUT_EN
  , parameter logic [31:0] MMIO_ADDR = 32'hFFFF_FFF0
`endif
) (
  input  logic                 clk,
  input  logic                 reset_n,
  data_mem_responder_if.slave  bus
`ifdef MMIO_OUT_EN
  , output logic [31:0]        mmio_out
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = 4;
  localparam logic [2:0]  F3_B  = 3'b000;
  localparam logic [2:0]  F3_W  = 3'b010;
  localparam logic [2:0]  F3_BU = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic          r_write;
  logic [2:0]    r_funct3;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic          r_req_ready;
  logic          r_rsp_valid;
  logic          r_rsp_err;
  logic [31:0]   r_rsp_rdata;
  logic [31:0]   r_mem [DEPTH];

  logic          w_accept, w_commit;
  logic          w_in_ram, w_is_mmio, w_err;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_lane;
  logic [31:0]   w_mmio_q, w_word, w_load, w_store;
  logic [7:0]    w_byte;

`ifdef MMIO_OUT_EN
  logic [31:0] r_mmio;
  assign w_is_mmio = (r_addr[31:2] == MMIO_ADDR[31:2]);
  assign w_mmio_q  = r_mmio;
  assign mmio_out  = r_mmio;
`else
  assign w_is_mmio = 1'b0;
  assign w_mmio_q  = '0;
`endif

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;

  assign w_in_ram = ({2'b00, r_addr[31:2]} < 32'(DEPTH));
  assign w_idx    = r_addr[AW+1:2];
  assign w_lane   = r_addr[1:0];

  // Access legality, evaluated on the latched request
  always_comb begin
    w_err = 1'b0;
    case (r_funct3)
      F3_B:    w_err = 1'b0;
      F3_W:    w_err = (w_lane != 2'b00);
      F3_BU:   w_err = r_write;
      default: w_err = 1'b1;
    endcase
    if (!w_in_ram && !w_is_mmio) w_err = 1'b1;
  end

  // Read-modify-write lane merge and load extension
  always_comb begin
    w_word  = w_is_mmio ? w_mmio_q : r_mem[w_idx];
    w_byte  = w_word[{w_lane, 3'b000} +: 8];
    w_store = w_word;
    if (r_funct3 == F3_W) w_store = r_wdata;
    else                  w_store[{w_lane, 3'b000} +: 8] = r_wdata[7:0];
    case (r_funct3)
      F3_W:    w_load = w_word;
      F3_B:    w_load = {{24{w_byte[7]}}, w_byte};
      default: w_load = {24'h0, w_byte};
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: if (bus.req_valid) begin
        w_accept    = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: if (r_cnt == '0) begin
        w_commit    = 1'b1;
        w_state_nxt = S_RESP;
      end
      S_RESP: if (bus.rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_funct3    <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
`ifdef MMIO_OUT_EN
      r_mmio      <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= (w_state_nxt == S_IDLE);
      r_rsp_valid <= (w_state_nxt == S_RESP);
      if (w_accept) begin
        r_write  <= bus.req_write;
        r_funct3 <= bus.req_funct3;
        r_addr   <= bus.req_addr;
        r_wdata  <= bus.req_wdata;
        r_cnt    <= CW'(WAIT_STATES);
      end else if (r_state == S_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_commit) begin
        r_rsp_err   <= w_err;
        r_rsp_rdata <= (w_err || r_write) ? '0 : w_load;
      end
`ifdef MMIO_OUT_EN
      if (w_commit && !w_err && r_write && w_is_mmio) r_mmio <= w_store;
`endif
    end
  end

  // RAM is deliberately not reset; a request dropped by reset never reaches commit
  always_ff @(posedge clk) begin
    if (w_commit && !w_err && r_write && !w_is_mmio) r_mem[w_idx] <= w_store;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: instance A runs with WAIT_STATES=2, instance B with WAIT_STATES=3.
module tb_data_mem_responder;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        t_write;
  logic [2:0]  t_f3;
  logic [31:0] t_addr, t_wdata;
  logic [1:0]  t_req_valid, t_rsp_ready;
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  data_mem_responder_if bus_a();
  data_mem_responder_if bus_b();

  assign bus_a.req_valid  = t_req_valid[0];
  assign bus_a.rsp_ready  = t_rsp_ready[0];
  assign bus_a.req_write  = t_write;
  assign bus_a.req_funct3 = t_f3;
  assign bus_a.req_addr   = t_addr;
  assign bus_a.req_wdata  = t_wdata;
  assign bus_b.req_valid  = t_req_valid[1];
  assign bus_b.rsp_ready  = t_rsp_ready[1];
  assign bus_b.req_write  = t_write;
  assign bus_b.req_funct3 = t_f3;
  assign bus_b.req_addr   = t_addr;
  assign bus_b.req_wdata  = t_wdata;

`ifdef MMIO_OUT_EN
  logic [31:0] mmio_a, mmio_b;
`endif

  data_mem_responder #(.DEPTH(256), .WAIT_STATES(2)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a)
`ifdef MMIO_OUT_EN
    , .mmio_out(mmio_a)
`endif
  );

  data_mem_responder #(.DEPTH(256), .WAIT_STATES(3)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b)
`ifdef MMIO_OUT_EN
    , .mmio_out(mmio_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", tag, act, exp);
    else n_pass++;
  endtask

  // One full transaction; lat counts edges from accept to rsp_valid (capped)
  task automatic do_req(input int sel, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    t_write = wr; t_f3 = f3; t_addr = a; t_wdata = d;
    t_req_valid[sel] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    t_req_valid[sel] = 1'b0;
    lat = 0;
    while (!((sel == 0) ? bus_a.rsp_valid : bus_b.rsp_valid) && lat < 40) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    rd = (sel == 0) ? bus_a.rsp_rdata : bus_b.rsp_rdata;
    er = (sel == 0) ? bus_a.rsp_err : bus_b.rsp_err;
    t_rsp_ready[sel] = 1'b1;
    @(posedge clk);
    #1 t_rsp_ready[sel] = 1'b0;
  endtask

  task automatic txn(input int sel, input logic wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rd, input logic exp_err, input string tag);
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_req(sel, wr, f3, a, d, rd, er, lat);
    check({tag, ".rdata"}, rd, exp_rd);
    check({tag, ".err"}, 32'(er), 32'(exp_err));
    check({tag, ".lat"}, 32'(lat), (sel == 0) ? 32'd3 : 32'd4);
  endtask

  initial begin
    int w;
    reset_n = 1'b0; t_write = 1'b0; t_f3 = '0; t_addr = '0; t_wdata = '0;
    t_req_valid = '0; t_rsp_ready = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.ctl", {29'h0, bus_a.req_ready, bus_a.rsp_valid, bus_a.rsp_err}, 32'h4);
    check("rst.rdata", bus_a.rsp_rdata, 32'h0);
    reset_n = 1'b1;

    // Word store/load and latency
    txn(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "sw10");
    txn(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "lw10");
    // Byte lanes
    txn(0, 1'b1, 3'b000, 32'h11, 32'h123456AA, 32'h0, 1'b0, "sb11");
    txn(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADAAEF, 1'b0, "lw10b");
    txn(0, 1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0, "lbu13");
    txn(0, 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, "lb13");
    txn(0, 1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFAA, 1'b0, "lb11");
    txn(0, 1'b0, 3'b100, 32'h10, 32'h0, 32'h000000EF, 1'b0, "lbu10");
    txn(0, 1'b1, 3'b010, 32'h14, 32'h00000042, 32'h0, 1'b0, "sw14");
    txn(0, 1'b0, 3'b000, 32'h14, 32'h0, 32'h00000042, 1'b0, "lb14pos");
    // Misalignment and illegal store type
    txn(0, 1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1, "lw12mis");
    txn(0, 1'b1, 3'b010, 32'h16, 32'h1, 32'h0, 1'b1, "sw16mis");
    txn(0, 1'b0, 3'b010, 32'h14, 32'h0, 32'h00000042, 1'b0, "lw14keep");
    txn(0, 1'b1, 3'b100, 32'h10, 32'h0, 32'h0, 1'b1, "sbu_bad");
    // Range boundary and bad funct3
    txn(0, 1'b1, 3'b010, 32'h0, 32'hA5A5A5A5, 32'h0, 1'b0, "sw0");
    txn(0, 1'b1, 3'b010, 32'h3FC, 32'h11223344, 32'h0, 1'b0, "sw3fc");
    txn(0, 1'b0, 3'b010, 32'h3FC, 32'h0, 32'h11223344, 1'b0, "lw3fc");
    txn(0, 1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b1, "lw400");
    txn(0, 1'b1, 3'b010, 32'h400, 32'h99, 32'h0, 1'b1, "sw400");
    txn(0, 1'b0, 3'b010, 32'h0, 32'h0, 32'hA5A5A5A5, 1'b0, "lw0alias");
    txn(0, 1'b0, 3'b001, 32'h10, 32'h0, 32'h0, 1'b1, "ld_f001");
    txn(0, 1'b1, 3'b001, 32'h10, 32'h0, 32'h0, 1'b1, "st_f001");
    txn(0, 1'b0, 3'b110, 32'h10, 32'h0, 32'h0, 1'b1, "ld_f110");
    txn(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADAAEF, 1'b0, "lw10keep");
`ifdef MMIO_OUT_EN
    txn(0, 1'b1, 3'b010, 32'hFFFF_FFF0, 32'hCAFE0001, 32'h0, 1'b0, "mmio_sw");
    check("mmio_out", mmio_a, 32'hCAFE0001);
    txn(0, 1'b0, 3'b000, 32'hFFFF_FFF3, 32'h0, 32'hFFFFFFCA, 1'b0, "mmio_lb");
`else
    txn(0, 1'b1, 3'b010, 32'hFFFF_FFF0, 32'hCAFE0001, 32'h0, 1'b1, "mmio_oor");
`endif

    // Response backpressure with a competing request held on the bus
    @(negedge clk);
    t_write = 1'b0; t_f3 = 3'b010; t_addr = 32'h10; t_wdata = '0;
    t_req_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    t_write = 1'b1; t_addr = 32'h10; t_wdata = 32'h0;
    w = 0;
    while (!bus_a.rsp_valid && w < 40) begin
      @(posedge clk); w++; @(negedge clk);
    end
    check("hold.lat", 32'(w), 32'd3);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold%0d.ctl", i), {29'h0, bus_a.req_ready, bus_a.rsp_valid, bus_a.rsp_err}, 32'h2);
      check($sformatf("hold%0d.rdata", i), bus_a.rsp_rdata, 32'hDEADAAEF);
      @(posedge clk); @(negedge clk);
    end
    t_addr = 32'h18; t_wdata = 32'h5A;
    t_rsp_ready[0] = 1'b1;
    @(posedge clk);
    #1 t_rsp_ready[0] = 1'b0;
    check("hs.ctl", {30'h0, bus_a.req_ready, bus_a.rsp_valid}, 32'h2);
    @(posedge clk);
    #1 t_req_valid[0] = 1'b0;
    w = 0;
    while (!bus_a.rsp_valid && w < 40) begin
      @(posedge clk); w++; #1;
    end
    check("next.lat", 32'(w), 32'd3);
    check("next.err", 32'(bus_a.rsp_err), 32'h0);
    t_rsp_ready[0] = 1'b1;
    @(posedge clk);
    #1 t_rsp_ready[0] = 1'b0;
    txn(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADAAEF, 1'b0, "lw10after");
    txn(0, 1'b0, 3'b010, 32'h18, 32'h0, 32'h0000005A, 1'b0, "lw18");

    // Reset during WAIT drops the pending store
    txn(1, 1'b1, 3'b010, 32'h20, 32'h77, 32'h0, 1'b0, "b_sw20");
    txn(1, 1'b0, 3'b010, 32'h20, 32'h0, 32'h77, 1'b0, "b_lw20");
    @(negedge clk);
    t_write = 1'b1; t_f3 = 3'b010; t_addr = 32'h20; t_wdata = 32'h55;
    t_req_valid[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    t_req_valid[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("b_wait.ctl", {29'h0, bus_b.req_ready, bus_b.rsp_valid, bus_b.rsp_err}, 32'h0);
    reset_n = 1'b0;
    #1;
    check("b_rst.ctl", {29'h0, bus_b.req_ready, bus_b.rsp_valid, bus_b.rsp_err}, 32'h4);
    check("b_rst.rdata", bus_b.rsp_rdata, 32'h0);
`ifdef MMIO_OUT_EN
    check("a_rst.mmio", mmio_a, 32'h0);
`endif
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("b_post.ctl", {29'h0, bus_b.req_ready, bus_b.rsp_valid, bus_b.rsp_err}, 32'h4);
    txn(1, 1'b0, 3'b010, 32'h20, 32'h0, 32'h77, 1'b0, "b_lw20keep");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
